// File: rtl/ysyx_25010008_lsu_pkg.sv
// Shared types and constants for the data-side load/store unit.
// States, access-size encodings, AXI response codes and the alignment predicate.
package ysyx_25010008_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WRITE,
        ST_WRESP,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Reserved size 3 behaves as a word access, so it needs word alignment too.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25010008_lsu_if.sv
// Core-side request/response bundle and AXI4-Lite bundle for the LSU.
// In both interfaces "master" is the initiating side and "slave" the responder.
interface ysyx_25010008_lsu_req_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface ysyx_25010008_lsu_axi_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic              bready;
    logic [1:0]        bresp;
    logic              bvalid;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_25010008_lsu_align.sv
// Combinational byte-lane logic: store shift/strobe and load extract/extend.
// One instance serves the store path, another the load path.
module ysyx_25010008_lsu_align
    import ysyx_25010008_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    input  logic [31:0] data_in,
    output logic [31:0] store_data,
    output logic [3:0]  store_strb,
    output logic [31:0] load_data
);
    logic [31:0] shifted;

    always_comb begin
        store_data = data_in << {off, 3'b000};
        shifted    = data_in >> {off, 3'b000};
        case (size)
            SZ_BYTE: begin
                store_strb = 4'b0001 << off;
                load_data  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                // Offset 3 shifts the upper lane out of a 4-bit strobe on purpose.
                store_strb = 4'b0011 << off;
                load_data  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                store_strb = 4'b1111;
                load_data  = shifted;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25010008_lsu.sv
// Single-outstanding load/store unit driving the data-side AXI4-Lite master port.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned half/word accesses with an error, no bus cycle.
module ysyx_25010008_lsu
    import ysyx_25010008_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    ysyx_25010008_lsu_req_if.slave req,
    ysyx_25010008_lsu_axi_if.master axi
);
    lsu_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [1:0]        size_reg, size_next;
    logic              unsigned_reg, unsigned_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [3:0]        wstrb_reg, wstrb_next;
    logic              aw_done_reg, aw_done_next;
    logic              w_done_reg, w_done_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;

    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] ld_data;
    logic [31:0] unused_st_load;
    logic [31:0] unused_ld_store;
    logic [3:0]  unused_ld_strb;

    ysyx_25010008_lsu_align u_store_align (
        .size       (req.req_size),
        .off        (req.req_addr[1:0]),
        .sign_ext   (1'b0),
        .data_in    (req.req_wdata),
        .store_data (st_data),
        .store_strb (st_strb),
        .load_data  (unused_st_load)
    );

    ysyx_25010008_lsu_align u_load_align (
        .size       (size_reg),
        .off        (addr_reg[1:0]),
        .sign_ext   (~unsigned_reg),
        .data_in    (axi.rdata),
        .store_data (unused_ld_store),
        .store_strb (unused_ld_strb),
        .load_data  (ld_data)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            size_reg     <= '0;
            unsigned_reg <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            size_reg     <= size_next;
            unsigned_reg <= unsigned_next;
            wdata_reg    <= wdata_next;
            wstrb_reg    <= wstrb_next;
            aw_done_reg  <= aw_done_next;
            w_done_reg   <= w_done_next;
            rdata_reg    <= rdata_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        size_next     = size_reg;
        unsigned_next = unsigned_reg;
        wdata_next    = wdata_reg;
        wstrb_next    = wstrb_reg;
        aw_done_next  = aw_done_reg;
        w_done_next   = w_done_reg;
        rdata_next    = rdata_reg;
        err_next      = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req.req_valid && req.req_ready) begin
                    addr_next     = req.req_addr;
                    size_next     = req.req_size;
                    unsigned_next = req.req_unsigned;
                    wdata_next    = st_data;
                    wstrb_next    = st_strb;
                    aw_done_next  = 1'b0;
                    w_done_next   = 1'b0;
                    rdata_next    = '0;
                    err_next      = 1'b0;
                    state_next    = req.req_wen ? ST_WRITE : ST_RADDR;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(req.req_size, req.req_addr[1:0])) begin
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end
`endif
                end
            end
            ST_RADDR: begin
                if (axi.arready) state_next = ST_RDATA;
            end
            ST_RDATA: begin
                if (axi.rvalid) begin
                    rdata_next = ld_data;
                    err_next   = axi.rresp != RESP_OKAY;
                    state_next = ST_RESP;
                end
            end
            ST_WRITE: begin
                // aw and w complete independently; leave once both have handshaken.
                aw_done_next = aw_done_reg | axi.awready;
                w_done_next  = w_done_reg | axi.wready;
                if (aw_done_next && w_done_next) state_next = ST_WRESP;
            end
            ST_WRESP: begin
                if (axi.bvalid) begin
                    err_next   = axi.bresp != RESP_OKAY;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (req.resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign req.req_ready  = (state_reg == ST_IDLE) && reset;
    assign req.resp_valid = state_reg == ST_RESP;
    assign req.resp_rdata = rdata_reg;
    assign req.resp_err   = err_reg;

    assign axi.araddr  = addr_reg;
    assign axi.arvalid = state_reg == ST_RADDR;
    assign axi.rready  = state_reg == ST_RDATA;
    assign axi.awaddr  = addr_reg;
    assign axi.awvalid = (state_reg == ST_WRITE) && !aw_done_reg;
    assign axi.wdata   = wdata_reg;
    assign axi.wstrb   = wstrb_reg;
    assign axi.wvalid  = (state_reg == ST_WRITE) && !w_done_reg;
    assign axi.bready  = state_reg == ST_WRESP;

endmodule
